// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline/CP0 side bundle for cp0_exc_ctrl (IntReq present under CP0_EXT_INT_EN)
interface cp0_exc_ctrl_if;
`ifdef CP0_EXT_INT_EN
    logic [5:0]  IntReq;
`endif
    logic        ExcReq;
    logic [4:0]  ExcCode;
    logic [31:0] ExcPC;
    logic        Eret;
    logic        MtcReq;
    logic [4:0]  MtcReg;
    logic [31:0] MtcData;
    logic        MtcAck;
    logic        CP0Wr;
    logic [4:0]  W_Reg;
    logic [31:0] W_data;
    logic [4:0]  R_Reg;
    logic [31:0] R_data;
    logic        Stall;
    logic        PCRedirect;
    logic [31:0] RedirectPC;

    modport master (
`ifdef CP0_EXT_INT_EN
        output IntReq,
`endif
        output ExcReq, ExcCode, ExcPC, Eret, MtcReq, MtcReg, MtcData, R_data,
        input  MtcAck, CP0Wr, W_Reg, W_data, R_Reg, Stall, PCRedirect, RedirectPC
    );

    modport slave (
`ifdef CP0_EXT_INT_EN
        input  IntReq,
`endif
        input  ExcReq, ExcCode, ExcPC, Eret, MtcReq, MtcReg, MtcData, R_data,
        output MtcAck, CP0Wr, W_Reg, W_data, R_Reg, Stall, PCRedirect, RedirectPC
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/ERET sequencer and single-port write arbiter
// Define CP0_EXT_INT_EN to accept masked external interrupts as code-0 exceptions.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
    parameter logic [4:0]  STATUS_REG   = 5'd12,
    parameter logic [4:0]  CAUSE_REG    = 5'd13,
    parameter logic [4:0]  EPC_REG      = 5'd14
) (
    input logic           CLK,
    input logic           Reset,
    cp0_exc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_EPC, S_W_CAUSE, S_W_STATUS, S_ERET_RD, S_ERET_CLR, S_REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] status_q, status_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] redir_q, redir_d;
    logic        int_take;
    logic [5:0]  ip_w;

    logic        cp0_wr, mtc_ack, stall, pc_redirect;
    logic [4:0]  w_reg, r_reg;
    logic [31:0] w_data, redirect_pc;

`ifdef CP0_EXT_INT_EN
    logic [5:0]  ip_q, ip_d;
    assign int_take = bus.R_data[0] & ~bus.R_data[1] & (|(bus.IntReq & bus.R_data[15:10]));
    assign ip_w     = ip_q;
`else
    assign int_take = 1'b0;
    assign ip_w     = 6'd0;
`endif

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        status_d    = status_q;
        code_d      = code_q;
        redir_d     = redir_q;
`ifdef CP0_EXT_INT_EN
        ip_d        = ip_q;
`endif
        cp0_wr      = 1'b0;
        w_reg       = 5'd0;
        w_data      = 32'd0;
        r_reg       = STATUS_REG;
        mtc_ack     = 1'b0;
        stall       = 1'b1;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;

        case (state_q)
            S_IDLE: begin
                stall = 1'b0;
                if (bus.ExcReq || int_take) begin
                    epc_d    = bus.ExcPC;
                    code_d   = bus.ExcReq ? bus.ExcCode : 5'd0;
                    status_d = bus.R_data;
`ifdef CP0_EXT_INT_EN
                    ip_d     = bus.IntReq;
`endif
                    // A nested exception keeps the original EPC intact.
                    state_d  = bus.R_data[1] ? S_W_CAUSE : S_W_EPC;
                end else if (bus.Eret) begin
                    status_d = bus.R_data;
                    state_d  = S_ERET_RD;
                end else if (bus.MtcReq) begin
                    cp0_wr  = 1'b1;
                    w_reg   = bus.MtcReg;
                    w_data  = bus.MtcData;
                    mtc_ack = 1'b1;
                end
            end
            S_W_EPC: begin
                cp0_wr  = 1'b1;
                w_reg   = EPC_REG;
                w_data  = epc_q;
                state_d = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                cp0_wr  = 1'b1;
                w_reg   = CAUSE_REG;
                w_data  = {16'd0, ip_w, 3'd0, code_q, 2'b00};
                state_d = S_W_STATUS;
            end
            S_W_STATUS: begin
                cp0_wr  = 1'b1;
                w_reg   = STATUS_REG;
                w_data  = status_q | 32'h2;
                redir_d = HANDLER_ADDR;
                state_d = S_REDIR;
            end
            S_ERET_RD: begin
                r_reg   = EPC_REG;
                redir_d = bus.R_data;
                state_d = S_ERET_CLR;
            end
            S_ERET_CLR: begin
                cp0_wr  = 1'b1;
                w_reg   = STATUS_REG;
                w_data  = status_q & ~32'h2;
                state_d = S_REDIR;
            end
            S_REDIR: begin
                pc_redirect = 1'b1;
                redirect_pc = redir_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The reset cycle must not disturb CP0 or the pipeline.
        if (Reset) begin
            cp0_wr      = 1'b0;
            w_reg       = 5'd0;
            w_data      = 32'd0;
            mtc_ack     = 1'b0;
            stall       = 1'b0;
            pc_redirect = 1'b0;
            redirect_pc = 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            epc_q    <= 32'd0;
            status_q <= 32'd0;
            code_q   <= 5'd0;
            redir_q  <= 32'd0;
`ifdef CP0_EXT_INT_EN
            ip_q     <= 6'd0;
`endif
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            status_q <= status_d;
            code_q   <= code_d;
            redir_q  <= redir_d;
`ifdef CP0_EXT_INT_EN
            ip_q     <= ip_d;
`endif
        end
    end

    assign bus.CP0Wr      = cp0_wr;
    assign bus.W_Reg      = w_reg;
    assign bus.W_data     = w_data;
    assign bus.R_Reg      = r_reg;
    assign bus.MtcAck     = mtc_ack;
    assign bus.Stall      = stall;
    assign bus.PCRedirect = pc_redirect;
    assign bus.RedirectPC = redirect_pc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl with a CP0 register file model
module tb_cp0_exc_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus();
    cp0_exc_ctrl dut (.CLK(clk), .Reset(rst), .bus(bus));

    logic [31:0] cp0     [32];
    logic [31:0] ref_cp0 [32];

    initial for (int i = 0; i < 32; i++) cp0[i] = 32'd0;
    always @(negedge clk) if (bus.CP0Wr === 1'b1) cp0[bus.W_Reg] <= bus.W_data;
    assign bus.R_data = cp0[bus.R_Reg];
`ifdef CP0_EXT_INT_EN
    assign bus.IntReq = 6'd0;
`endif

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic        ack;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    function automatic void push_wr(input logic [4:0] r, input logic [31:0] d, input logic ack);
        wr_t e;
        e.r = r; e.d = d; e.ack = ack;
        wq.push_back(e);
        ref_cp0[r] = d;
    endfunction

    // Monitor: every CP0 write and every redirect must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.CP0Wr === 1'b1) begin
                if (wq.size() == 0) flag("unexpected_write", {27'd0, bus.W_Reg});
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("w_reg", {27'd0, bus.W_Reg}, {27'd0, e.r});
                    check("w_data", bus.W_data, e.d);
                    check("mtc_ack", {31'd0, bus.MtcAck}, {31'd0, e.ack});
                end
            end else if (bus.MtcAck === 1'b1) flag("ack_without_write", {27'd0, bus.MtcReg});
            if (bus.PCRedirect === 1'b1) begin
                check("cp0wr_in_redir", {31'd0, bus.CP0Wr}, 32'd0);
                if (rq.size() == 0) flag("unexpected_redirect", bus.RedirectPC);
                else check("redirect_pc", bus.RedirectPC, rq.pop_front());
            end
        end
    end

    task automatic wait_redirect(input int exp_lat, input string name);
        int k = 0;
        bit got = 0;
        @(posedge clk);
        while (!got && k < 12) begin
            @(negedge clk);
            k++;
            if (bus.Stall === 1'b1) begin bus.ExcReq = 1'b0; bus.Eret = 1'b0; end
            if (bus.PCRedirect === 1'b1) got = 1;
        end
        bus.ExcReq = 1'b0;
        bus.Eret   = 1'b0;
        check(name, got ? k : 99, exp_lat);
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                          input bit with_mtc, input logic [4:0] mreg, input logic [31:0] mdata);
        logic [31:0] st;
        bit seen = 0;
        st = ref_cp0[12];
        if (!st[1]) push_wr(5'd14, pc, 1'b0);
        push_wr(5'd13, {25'd0, code, 2'b00}, 1'b0);
        push_wr(5'd12, st | 32'h2, 1'b0);
        rq.push_back(32'h180);
        if (with_mtc) push_wr(mreg, mdata, 1'b1);
        bus.ExcReq = 1'b1; bus.ExcCode = code; bus.ExcPC = pc;
        bus.MtcReq = with_mtc; bus.MtcReg = mreg; bus.MtcData = mdata;
        wait_redirect(st[1] ? 3 : 4, "exc_latency");
        if (with_mtc) begin
            for (int k = 0; k < 6 && !seen; k++) begin
                @(negedge clk);
                if (bus.MtcAck === 1'b1) seen = 1;
            end
            check("deferred_mtc_ack", {31'd0, seen}, 32'd1);
        end
        @(posedge clk); #1;
        bus.MtcReq = 1'b0;
    endtask

    task automatic do_eret();
        push_wr(5'd12, ref_cp0[12] & ~32'h2, 1'b0);
        rq.push_back(ref_cp0[14]);
        bus.Eret = 1'b1;
        wait_redirect(3, "eret_latency");
        @(posedge clk); #1;
    endtask

    task automatic do_mtc(input logic [4:0] r, input logic [31:0] d);
        push_wr(r, d, 1'b1);
        bus.MtcReq = 1'b1; bus.MtcReg = r; bus.MtcData = d;
        @(negedge clk);
        check("mtc_same_cycle_ack", {31'd0, bus.MtcAck}, 32'd1);
        @(posedge clk); #1;
        bus.MtcReq = 1'b0;
    endtask

    task automatic do_reset_mid(input logic [31:0] pc);
        push_wr(5'd14, pc, 1'b0);
        bus.ExcReq = 1'b1; bus.ExcCode = 5'd9; bus.ExcPC = pc;
        @(posedge clk); #1;
        bus.ExcReq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("cp0wr_on_reset_cycle", {31'd0, bus.CP0Wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("stall_after_reset", {31'd0, bus.Stall}, 32'd0);
        check("redirect_after_reset", {31'd0, bus.PCRedirect}, 32'd0);
        check("epc_kept", cp0[14], pc);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_cp0[i] = 32'd0;
        rst = 1'b1;
        bus.ExcReq = 1'b0; bus.ExcCode = 5'd0; bus.ExcPC = 32'd0; bus.Eret = 1'b0;
        bus.MtcReq = 1'b0; bus.MtcReg = 5'd0; bus.MtcData = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cp0wr", {31'd0, bus.CP0Wr}, 32'd0);
        check("rst_stall", {31'd0, bus.Stall}, 32'd0);
        check("rst_redirect", {31'd0, bus.PCRedirect}, 32'd0);
        check("rst_redirect_pc", bus.RedirectPC, 32'd0);
        check("rst_w_data", bus.W_data, 32'd0);
        check("rst_w_reg", {27'd0, bus.W_Reg}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_r_reg", {27'd0, bus.R_Reg}, 32'd12);
        @(posedge clk); #1;

        do_exc(5'd8, 32'h40, 0, 5'd0, 32'd0);
        do_exc(5'd4, 32'h80, 0, 5'd0, 32'd0);
        do_mtc(5'd14, 32'h1234);
        do_mtc(5'd12, 32'h3);
        do_eret();
        do_mtc(5'd12, 32'hFF01);
        do_exc(5'd10, 32'h200, 1, 5'd12, 32'hFF01);
        do_mtc(5'd12, 32'h0);
        do_reset_mid(32'hABCD_0000);

        for (int it = 0; it < 40; it++) begin
            logic [4:0] mreg;
            case ($urandom_range(0, 3))
                0: mreg = 5'd12;
                1: mreg = 5'd13;
                2: mreg = 5'd14;
                default: mreg = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0: do_exc(5'($urandom), $urandom, 0, 5'd0, 32'd0);
                1: do_eret();
                2: do_mtc(mreg, $urandom);
                default: do_exc(5'($urandom), $urandom, 1, mreg, $urandom);
            endcase
        end

        repeat (4) @(negedge clk);
        check("write_queue_left", wq.size(), 32'd0);
        check("redirect_queue_left", rq.size(), 32'd0);
        for (int r = 12; r <= 14; r++) check("final_cp0", cp0[r], ref_cp0[r]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
